// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide, sign fix-up stage.
// Optional macro MULDIV_EARLY_EXIT_EN: a multiply ends once its remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 5,
  parameter int CNTW    = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [REGADDR-1:0] dest_in,
  input  logic               flush,
  output logic               busy,
  output logic               stall,
  output logic               done,
  output logic [WIDTH-1:0]   result_hi,
  output logic [WIDTH-1:0]   result_lo,
  output logic [REGADDR-1:0] dest_out,
  output logic               div0
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [CNTW-1:0]      r_cnt;
  logic [1:0]           r_op;
  logic [REGADDR-1:0]   r_dest, r_dest_out;
  logic                 r_sa, r_sb, r_bzero, r_div0;
  logic [WIDTH-1:0]     r_araw, r_dvsr, r_hi, r_lo;
  logic [2*WIDTH-1:0]   r_acc;

  logic                 w_na, w_nb, w_accept, w_is_div, w_early, w_done;
  logic [WIDTH-1:0]     w_amag, w_bmag, w_q, w_r, w_q_fix, w_r_fix, w_hi_fix, w_lo_fix;
  logic [WIDTH:0]       w_madd, w_trial;
  logic [2*WIDTH-1:0]   w_mul_step, w_div_step, w_acc_run, w_prod_fix;

  // Magnitudes are formed only for signed ops (op[0]) with a negative operand.
  assign w_na     = op[0] & a[WIDTH-1];
  assign w_nb     = op[0] & b[WIDTH-1];
  assign w_amag   = w_na ? -a : a;
  assign w_bmag   = w_nb ? -b : b;
  assign w_accept = (r_state == S_IDLE) & start & ~flush;
  assign w_is_div = r_op[1];

  assign w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_dvsr} : '0);
  assign w_mul_step = {w_madd, r_acc[WIDTH-1:1]};
  assign w_trial    = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_dvsr};
  assign w_div_step = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

`ifdef MULDIV_EARLY_EXIT_EN
  logic [CNTW-1:0]  w_shamt;
  logic [WIDTH-1:0] w_mask;
  assign w_shamt = CNTW'(WIDTH - 1) - r_cnt;
  assign w_mask  = {WIDTH{1'b1}} >> w_shamt;
  // acc[cnt:0] holds the unconsumed multiplier; bit 0 is consumed this cycle, the rest must be zero
  assign w_early   = ~w_is_div & (((r_acc[WIDTH-1:0] & w_mask) >> 1) == '0);
  assign w_acc_run = w_early ? (w_mul_step >> r_cnt) : (w_is_div ? w_div_step : w_mul_step);
`else
  assign w_early   = 1'b0;
  assign w_acc_run = w_is_div ? w_div_step : w_mul_step;
`endif

  assign w_prod_fix = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_q        = r_acc[WIDTH-1:0];
  assign w_r        = r_acc[2*WIDTH-1:WIDTH];
  assign w_q_fix    = (r_sa ^ r_sb) ? -w_q : w_q;
  assign w_r_fix    = r_sa ? -w_r : w_r;

  always_comb begin
    w_hi_fix = w_prod_fix[2*WIDTH-1:WIDTH];
    w_lo_fix = w_prod_fix[WIDTH-1:0];
    if (w_is_div) begin
      if (r_bzero) begin
        w_hi_fix = r_araw;
        w_lo_fix = '1;
      end else begin
        w_hi_fix = w_r_fix;
        w_lo_fix = w_q_fix;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next = S_RUN;
        S_RUN:   if (r_cnt == '0 || w_early) w_next = S_FIX;
        S_FIX:   w_next = S_DONE;
        S_DONE: begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_dest     <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_bzero    <= 1'b0;
      r_araw     <= '0;
      r_dvsr     <= '0;
      r_acc      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_dest_out <= '0;
      r_div0     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op    <= op;
        r_dest  <= dest_in;
        r_sa    <= w_na;
        r_sb    <= w_nb;
        r_bzero <= (b == '0);
        r_araw  <= a;
        r_cnt   <= CNTW'(WIDTH - 1);
        if (op[1]) begin
          r_acc  <= {{WIDTH{1'b0}}, w_amag};
          r_dvsr <= w_bmag;
        end else begin
          r_acc  <= {{WIDTH{1'b0}}, w_bmag};
          r_dvsr <= w_amag;
        end
      end
      if (r_state == S_RUN && !flush) begin
        r_acc <= w_acc_run;
        r_cnt <= (r_cnt == '0) ? '0 : r_cnt - 1'b1;
      end
      if (r_state == S_FIX && !flush) begin
        r_hi       <= w_hi_fix;
        r_lo       <= w_lo_fix;
        r_dest_out <= r_dest;
        r_div0     <= w_is_div & r_bzero;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign stall     = start & busy;
  assign done      = w_done;
  assign result_hi = r_hi;
  assign result_lo = r_lo;
  assign dest_out  = r_dest_out;
  assign div0      = r_div0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, random ops against an arithmetic model,
// flush, stall and reset scenarios.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, flush;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic [4:0]   dest_in;
  logic         busy, stall, done, div0;
  logic [W-1:0] result_hi, result_lo;
  logic [4:0]   dest_out;

  int vectors = 0;
  int miscompares = 0;

  muldiv_unit #(.WIDTH(W), .REGADDR(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .dest_in(dest_in), .flush(flush), .busy(busy), .stall(stall), .done(done),
    .result_hi(result_hi), .result_lo(result_lo), .dest_out(dest_out), .div0(div0)
  );

  always #5 clk = ~clk;

  // Plain arithmetic reference: 64-bit products, truncating signed division.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] hi, output logic [W-1:0] lo, output logic d0);
    longint sx, sy, q, r;
    logic [2*W-1:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    d0 = 1'b0;
    p  = '0;
    case (o)
      2'd0:    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      2'd1:    p = 64'(sx * sy);
      default: p = '0;
    endcase
    hi = p[2*W-1:W];
    lo = p[W-1:0];
    if (o[1]) begin
      if (y == '0) begin
        hi = x; lo = '1; d0 = 1'b1;
      end else if (o[0]) begin
        q = sx / sy; r = sx % sy;
        hi = W'(r); lo = W'(q);
      end else begin
        hi = x % y; lo = x / y;
      end
    end
  endfunction

  // Negedges from the accepting edge to the first negedge that shows done.
  function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] y);
    int n;
    n = W;
`ifdef MULDIV_EARLY_EXIT_EN
    if (!o[1]) begin
      logic [W-1:0] m;
      m = (o[0] && y[W-1]) ? -y : y;
      n = 1;
      for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    end
`endif
    return n + 2;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [4:0] t, output logic [W-1:0] hi, output logic [W-1:0] lo,
                        output logic d0, output logic [4:0] dt, output int lat);
    @(negedge clk);
    op = o; a = x; b = y; dest_in = t; start = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (done === 1'b1) break;
    end
    hi = result_hi; lo = result_lo; d0 = div0; dt = dest_out;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; dest_in = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, stall, done, div0, dest_out, result_hi, result_lo} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b done=%b div0=%b dest=%h hi=%h lo=%h, expected all zero",
               busy, done, div0, dest_out, result_hi, result_lo);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_directed();
    logic [1:0]   t_op [7] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd3, 2'd0};
    logic [W-1:0] t_a  [7] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd10, 32'd3, 32'h80000000, 32'd12345};
    logic [W-1:0] t_b  [7] = '{32'd2, 32'd5, 32'd2, 32'd0, 32'd4, 32'hFFFFFFFF, 32'd3};
    logic [W-1:0] t_hi [7] = '{32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hA, 32'h0, 32'h0, 32'h0};
    logic [W-1:0] t_lo [7] = '{32'hFFFFFFFE, 32'hFFFFFFF1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd12, 32'h80000000, 32'd37035};
    logic         t_d0 [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [W-1:0] hi, lo;
    logic d0;
    logic [4:0] dt;
    int lat;
    for (int i = 0; i < 7; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 5'(i + 3), hi, lo, d0, dt, lat);
      vectors++;
      if (hi !== t_hi[i] || lo !== t_lo[i]) begin
        miscompares++;
        $display("FAIL directed_result[%0d]: got hi=%h lo=%h expected hi=%h lo=%h", i, hi, lo, t_hi[i], t_lo[i]);
      end
      vectors++;
      if (d0 !== t_d0[i] || dt !== 5'(i + 3)) begin
        miscompares++;
        $display("FAIL directed_tag_div0[%0d]: got div0=%b dest=%0d expected div0=%b dest=%0d", i, d0, dt, t_d0[i], i + 3);
      end
      vectors++;
      if (lat != exp_lat(t_op[i], t_b[i])) begin
        miscompares++;
        $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, exp_lat(t_op[i], t_b[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, hi, lo, eh, el;
    logic [1:0] o;
    logic d0, ed;
    logic [4:0] dt, t;
    int lat, sel;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom; y = $urandom; t = 5'($urandom);
      sel = $urandom_range(0, 7);
      if (sel == 0) y = '0;
      if (sel == 1) y = $urandom_range(0, 15);
      if (sel == 2) x = 32'h80000000;
      if (sel == 3) y = '1;
      model(o, x, y, eh, el, ed);
      run_op(o, x, y, t, hi, lo, d0, dt, lat);
      vectors++;
      if (hi !== eh || lo !== el || d0 !== ed) begin
        miscompares++;
        $display("FAIL random_result[%0d] op=%0d a=%h b=%h: got hi=%h lo=%h div0=%b expected hi=%h lo=%h div0=%b",
                 i, o, x, y, hi, lo, d0, eh, el, ed);
      end
      vectors++;
      if (dt !== t || lat != exp_lat(o, y)) begin
        miscompares++;
        $display("FAIL random_tag_latency[%0d]: got dest=%0d lat=%0d expected dest=%0d lat=%0d", i, dt, lat, t, exp_lat(o, y));
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL random_done_pulse[%0d]: got done=%b busy=%b expected 0/0", i, done, busy);
      end
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] sh, sl;
    logic [4:0] sd;
    logic s0;
    int seen;
    sh = result_hi; sl = result_lo; sd = dest_out; s0 = div0;
    @(negedge clk);
    op = 2'd2; a = 32'd100; b = 32'd7; dest_in = 5'd17; start = 1'b1;
    @(posedge clk);
    repeat (10) begin @(negedge clk); start = 1'b0; end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_busy: got %b expected 0", busy);
    end
    seen = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) seen++; end
    vectors++;
    if (seen != 0 || result_hi !== sh || result_lo !== sl || dest_out !== sd || div0 !== s0) begin
      miscompares++;
      $display("FAIL flush_outputs: done pulses=%0d hi=%h lo=%h dest=%h div0=%b expected 0 pulses hi=%h lo=%h dest=%h div0=%b",
               seen, result_hi, result_lo, dest_out, div0, sh, sl, sd, s0);
    end
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_start_idle: busy=%b expected 0", busy);
    end
    // flush landing on the DONE cycle hides the pulse
    start = 1'b1; op = 2'd2; a = 32'd55; b = 32'd5;
    @(posedge clk);
    repeat (W + 2) begin @(negedge clk); start = 1'b0; end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_done_pre: done=%b expected 1", done);
    end
    flush = 1'b1;
    #1;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_done_suppress: done=%b expected 0", done);
    end
    @(negedge clk);
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_done_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] a1, b1, a2, b2, eh, el, h1, l1;
    logic ed, d1;
    logic [4:0] t1;
    int n, bad, seen, lat;
    a1 = $urandom; b1 = $urandom_range(1, 1000);
    a2 = $urandom; b2 = $urandom;
    h1 = '0; l1 = '0; d1 = 1'b0; t1 = '0;
    @(negedge clk);
    op = 2'd2; a = a1; b = b1; dest_in = 5'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op = 2'd1; a = a2; b = b2; dest_in = 5'd22;
    n = 1; bad = 0; seen = 0;
    while (busy === 1'b1 && n < 200) begin
      if (stall !== 1'b1) bad++;
      if (done === 1'b1) begin
        seen = n; h1 = result_hi; l1 = result_lo; d1 = div0; t1 = dest_out;
      end
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bad != 0 || seen != exp_lat(2'd2, b1)) begin
      miscompares++;
      $display("FAIL stall_window: stall-low cycles=%0d done at %0d expected 0 and %0d", bad, seen, exp_lat(2'd2, b1));
    end
    model(2'd2, a1, b1, eh, el, ed);
    vectors++;
    if (h1 !== eh || l1 !== el || d1 !== ed || t1 !== 5'd9) begin
      miscompares++;
      $display("FAIL stall_first_result: got hi=%h lo=%h div0=%b dest=%0d expected hi=%h lo=%h div0=%b dest=9",
               h1, l1, d1, t1, eh, el, ed);
    end
    @(posedge clk);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (done === 1'b1) break;
    end
    model(2'd1, a2, b2, eh, el, ed);
    vectors++;
    if (result_hi !== eh || result_lo !== el || dest_out !== 5'd22 || lat != exp_lat(2'd1, b2)) begin
      miscompares++;
      $display("FAIL stall_held_op: got hi=%h lo=%h dest=%0d lat=%0d expected hi=%h lo=%h dest=22 lat=%0d",
               result_hi, result_lo, dest_out, lat, eh, el, exp_lat(2'd1, b2));
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    op = 2'd2; a = $urandom; b = 32'd3; dest_in = 5'd30; start = 1'b1;
    @(posedge clk);
    repeat (5) begin @(negedge clk); start = 1'b0; end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({busy, done, div0, dest_out, result_hi, result_lo} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got busy=%b done=%b div0=%b dest=%h hi=%h lo=%h expected all zero",
               busy, done, div0, dest_out, result_hi, result_lo);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) seen++; end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: busy/done cycles=%0d expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
